// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Write-back arbiter for the integer register file: round-robin between EXU and LSU,
// one registered write per cycle, plus a per-register busy scoreboard for issue hazards.
module ysyx_23060096_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_exu_valid,
    input  logic [ADDR_WIDTH-1:0] i_exu_rd,
    input  logic [DATA_WIDTH-1:0] i_exu_data,
    output logic                  o_exu_ready,
    input  logic                  i_lsu_valid,
    input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
    input  logic [DATA_WIDTH-1:0] i_lsu_data,
    output logic                  o_lsu_ready,
    input  logic                  i_iss_valid,
    input  logic                  i_iss_wr,
    input  logic [ADDR_WIDTH-1:0] i_iss_rd,
    input  logic [ADDR_WIDTH-1:0] i_iss_rs1,
    input  logic [ADDR_WIDTH-1:0] i_iss_rs2,
    output logic                  o_iss_stall,
    output logic                  o_rf_wen,
    output logic [ADDR_WIDTH-1:0] o_rf_waddr,
    output logic [DATA_WIDTH-1:0] o_rf_wdata,
    output logic                  o_sb_idle
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  r_ptrLsu;
    logic                  r_rfWen;
    logic [ADDR_WIDTH-1:0] r_rfWaddr;
    logic [DATA_WIDTH-1:0] r_rfWdata;
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      w_busyNext;

    logic w_exuReady;
    logic w_lsuReady;
    logic w_both;
    logic w_issFire;
    logic w_rs1Hit;
    logic w_rs2Hit;
    logic w_rdHit;

    // The pointer only breaks ties, so a lone valid source is granted regardless of it.
    assign w_both     = i_exu_valid & i_lsu_valid;
    assign w_exuReady = ~i_rst & i_exu_valid & (~i_lsu_valid | ~r_ptrLsu);
    assign w_lsuReady = ~i_rst & i_lsu_valid & (~i_exu_valid |  r_ptrLsu);

    assign w_rs1Hit   = (i_iss_rs1 != '0) & r_busy[i_iss_rs1];
    assign w_rs2Hit   = (i_iss_rs2 != '0) & r_busy[i_iss_rs2];
    assign w_rdHit    = i_iss_wr & (i_iss_rd != '0) & r_busy[i_iss_rd];
    assign o_iss_stall = i_iss_valid & (w_rs1Hit | w_rs2Hit | w_rdHit);
    assign w_issFire  = i_iss_valid & ~o_iss_stall & i_iss_wr & (i_iss_rd != '0);

    // Clear is applied before set so a new producer claiming the same register wins.
    always_comb begin
        w_busyNext = r_busy;
        if (r_rfWen) begin
            w_busyNext[r_rfWaddr] = 1'b0;
        end
        if (w_issFire) begin
            w_busyNext[i_iss_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptrLsu  <= 1'b0;
            r_rfWen   <= 1'b0;
            r_rfWaddr <= '0;
            r_rfWdata <= '0;
            r_busy    <= '0;
        end else begin
            r_busy  <= w_busyNext;
            r_rfWen <= 1'b0;
            if (w_both) begin
                r_ptrLsu <= ~r_ptrLsu;
            end
            if (w_exuReady) begin
                r_rfWen   <= (i_exu_rd != '0);
                r_rfWaddr <= i_exu_rd;
                r_rfWdata <= i_exu_data;
            end else if (w_lsuReady) begin
                r_rfWen   <= (i_lsu_rd != '0);
                r_rfWaddr <= i_lsu_rd;
                r_rfWdata <= i_lsu_data;
            end
        end
    end

    assign o_exu_ready = w_exuReady;
    assign o_lsu_ready = w_lsuReady;
    assign o_rf_wen    = r_rfWen;
    assign o_rf_waddr  = r_rfWaddr;
    assign o_rf_wdata  = r_rfWdata;
    assign o_sb_idle   = ~|r_busy;

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Directed bench for the write-back arbiter: reset, single writes, contention,
// RAW/WAW stalls, x0 handling, set/clear race and mid-operation reset.
module tb_ysyx_23060096_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exuValid, lsuValid, issValid, issWr;
    logic [4:0]  exuRd, lsuRd, issRd, issRs1, issRs2;
    logic [31:0] exuData, lsuData;
    logic        exuReady, lsuReady, issStall, rfWen, sbIdle;
    logic [4:0]  rfWaddr;
    logic [31:0] rfWdata;

    int passCount = 0;
    int totalCount = 0;

    always #5 clk = ~clk;

    ysyx_23060096_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_exu_valid(exuValid), .i_exu_rd(exuRd), .i_exu_data(exuData), .o_exu_ready(exuReady),
        .i_lsu_valid(lsuValid), .i_lsu_rd(lsuRd), .i_lsu_data(lsuData), .o_lsu_ready(lsuReady),
        .i_iss_valid(issValid), .i_iss_wr(issWr), .i_iss_rd(issRd),
        .i_iss_rs1(issRs1), .i_iss_rs2(issRs2), .o_iss_stall(issStall),
        .o_rf_wen(rfWen), .o_rf_waddr(rfWaddr), .o_rf_wdata(rfWdata), .o_sb_idle(sbIdle)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        exuValid = ev; exuRd = er; exuData = ed;
        lsuValid = lv; lsuRd = lr; lsuData = ld;
    endtask

    task automatic applyIssue(input logic v, input logic wr, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2);
        issValid = v; issWr = wr; issRd = rd; issRs1 = rs1; issRs2 = rs2;
    endtask

    // Advance to just after the next rising edge, then let combinational paths settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 5'd4, 32'h1, 1'b1, 5'd6, 32'h2);
        applyIssue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // T1 reset with both sources requesting
        tick(); #1;
        checkOutput("t1_exu_ready", {31'd0, exuReady}, 32'd0);
        checkOutput("t1_lsu_ready", {31'd0, lsuReady}, 32'd0);
        checkOutput("t1_rf_wen",    {31'd0, rfWen},    32'd0);
        checkOutput("t1_sb_idle",   {31'd0, sbIdle},   32'd1);
        tick();
        checkOutput("t1_rf_wen_2",  {31'd0, rfWen},    32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // T2 single EXU write
        tick();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("t2_exu_ready", {31'd0, exuReady}, 32'd1);
        checkOutput("t2_lsu_ready", {31'd0, lsuReady}, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("t2_rf_wen",   {31'd0, rfWen},   32'd1);
        checkOutput("t2_rf_waddr", {27'd0, rfWaddr}, 32'd5);
        checkOutput("t2_rf_wdata", rfWdata,          32'hDEADBEEF);
        tick();
        checkOutput("t2_rf_wen_off", {31'd0, rfWen},  32'd0);
        checkOutput("t2_sb_idle",    {31'd0, sbIdle}, 32'd1);

        // T3 contention: EXU wins first, then alternation
        applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
        #1;
        checkOutput("t3_c1_exu", {31'd0, exuReady}, 32'd1);
        checkOutput("t3_c1_lsu", {31'd0, lsuReady}, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd3, 32'hA3, 1'b1, 5'd2, 32'hB2);
        #1;
        checkOutput("t3_c2_exu",   {31'd0, exuReady}, 32'd0);
        checkOutput("t3_c2_lsu",   {31'd0, lsuReady}, 32'd1);
        checkOutput("t3_c2_waddr", {27'd0, rfWaddr},  32'd1);
        checkOutput("t3_c2_wdata", rfWdata,           32'hA1);
        tick();
        applyStimulus(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB4);
        #1;
        checkOutput("t3_c3_exu",   {31'd0, exuReady}, 32'd1);
        checkOutput("t3_c3_lsu",   {31'd0, lsuReady}, 32'd0);
        checkOutput("t3_c3_waddr", {27'd0, rfWaddr},  32'd2);
        checkOutput("t3_c3_wdata", rfWdata,           32'hB2);
        tick();
        #1;
        checkOutput("t3_c4_exu",   {31'd0, exuReady}, 32'd0);
        checkOutput("t3_c4_lsu",   {31'd0, lsuReady}, 32'd1);
        checkOutput("t3_c4_waddr", {27'd0, rfWaddr},  32'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("t3_c5_wen",   {31'd0, rfWen},   32'd1);
        checkOutput("t3_c5_waddr", {27'd0, rfWaddr}, 32'd4);
        checkOutput("t3_c5_wdata", rfWdata,          32'hB4);
        tick();
        checkOutput("t3_c6_wen",   {31'd0, rfWen},   32'd0);

        // T4 RAW and WAW hazards on x7
        applyIssue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        #1;
        checkOutput("t4_issue_nostall", {31'd0, issStall}, 32'd0);
        tick();
        applyIssue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
        #1;
        checkOutput("t4_raw_stall", {31'd0, issStall}, 32'd1);
        checkOutput("t4_sb_busy",   {31'd0, sbIdle},   32'd0);
        applyIssue(1'b1, 1'b0, 5'd0, 5'd0, 5'd7);
        #1;
        checkOutput("t4_rs2_stall", {31'd0, issStall}, 32'd1);
        applyIssue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        #1;
        checkOutput("t4_waw_stall", {31'd0, issStall}, 32'd1);
        tick();
        applyIssue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("t4_raw_hold",  {31'd0, issStall}, 32'd1);
        checkOutput("t4_exu_ready", {31'd0, exuReady}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("t4_wb_wen",     {31'd0, rfWen},    32'd1);
        checkOutput("t4_wb_waddr",   {27'd0, rfWaddr},  32'd7);
        checkOutput("t4_stall_pulse", {31'd0, issStall}, 32'd1);
        tick();
        checkOutput("t4_stall_drop", {31'd0, issStall}, 32'd0);
        checkOutput("t4_sb_idle",    {31'd0, sbIdle},   32'd1);

        // T5 x0 destination and sources
        applyIssue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        #1;
        checkOutput("t5_lsu_ready", {31'd0, lsuReady}, 32'd1);
        checkOutput("t5_x0_nostall", {31'd0, issStall}, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyIssue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("t5_rf_wen",  {31'd0, rfWen},  32'd0);
        checkOutput("t5_sb_idle", {31'd0, sbIdle}, 32'd1);

        // T6 set and clear of x3 on the same edge
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyIssue(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
        #1;
        checkOutput("t6_wen",      {31'd0, rfWen},    32'd1);
        checkOutput("t6_nostall",  {31'd0, issStall}, 32'd0);
        tick();
        applyIssue(1'b1, 1'b0, 5'd0, 5'd3, 5'd0);
        #1;
        checkOutput("t6_busy_kept", {31'd0, sbIdle},   32'd0);
        checkOutput("t6_raw_stall", {31'd0, issStall}, 32'd1);
        applyIssue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Mid-operation reset: pointer moved to LSU, pulse pending, x3 busy
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        #1;
        checkOutput("rst_pre_exu", {31'd0, exuReady}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_exu_ready", {31'd0, exuReady}, 32'd0);
        checkOutput("rst_lsu_ready", {31'd0, lsuReady}, 32'd0);
        tick();
        checkOutput("rst_rf_wen",  {31'd0, rfWen},  32'd0);
        checkOutput("rst_sb_idle", {31'd0, sbIdle}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rst_ptr_exu", {31'd0, exuReady}, 32'd1);
        checkOutput("rst_ptr_lsu", {31'd0, lsuReady}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
